rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer for the board clock/reset resource. It waits for the PLL lock to be stable, then releases per-domain resets in a fixed order with programmable gaps. It reasserts all domain resets on lock loss or on a software reset request. It sits between the clock generation and the datapath domains; each downstream domain re-synchronises its dom_rst bit locally.

Parameters:
N_DOM, 4, number of sequenced reset domains; bit 0 is released first.
LOCK_STABLE_CYC, 256, consecutive synchronised-lock cycles required before release; must be ≥1.
STEP_GAP_CYC, 16, cycles between successive domain releases; must be ≥1.
SRST_HOLD_CYC, 64, cycles all resets are held for a soft reset; must be ≥1.
CNT_W, 16, width of the internal counters; all *_CYC parameters must fit in it.

Ports:
clk_100m  in  1  sole clock.
rst  in  1  synchronous, active-high reset.
pll_locked  in  1  asynchronous PLL lock indication.
soft_rst_req  in  1  level soft-reset request, sampled only in RUN.
soft_rst_ack  out  1  one-cycle pulse at the end of the soft-reset hold.
dom_rst  out  N_DOM  active-high domain resets, registered.
all_released  out  1  high while in RUN.
state_o  out  3  current state encoding, for debug.
lock_loss_cnt  out  8  count of lock-loss events, saturating.

Behaviour:
- One clock (clk_100m); reset rst is synchronous and active-high.
- Reset values, effective at the next clock edge even mid-operation:
  - dom_rst = all ones
  - all_released = 0
  - soft_rst_ack = 0
  - lock_loss_cnt = 0
  - state = WAIT_LOCK
  - counters and index cleared
  - synchroniser flops cleared
- pll_locked passes through a 2-FF synchroniser giving locked_s; pin-to-locked_s latency is 2 cycles.
- WAIT_LOCK:
  - dom_rst all ones, counter cleared.
  - locked_s=1 → STABLE.
- STABLE:
  - Counter increments each cycle while locked_s=1.
  - locked_s=0 → WAIT_LOCK, counter cleared, not counted as a loss.
  - Counter reaching LOCK_STABLE_CYC-1 with locked_s=1 → RELEASE, idx=0, gap counter=0.
- RELEASE:
  - Gap counter counts STEP_GAP_CYC cycles, then clears dom_rst[idx] and increments idx.
  - With RELEASE first registered at cycle T, dom_rst[k] falls at T+(k+1)*STEP_GAP_CYC.
  - On the edge that clears dom_rst[N_DOM-1], state → RUN and all_released → 1 (same edge).
- RUN:
  - dom_rst all zero.
  - locked_s=0 → WAIT_LOCK next edge.
  - Otherwise soft_rst_req=1 → HOLD next edge: dom_rst all ones, all_released 0, hold counter cleared.
- HOLD:
  - Counts SRST_HOLD_CYC cycles.
  - On the final count, soft_rst_ack pulses for 1 cycle and state → RELEASE, skipping STABLE.
- Lock loss in RELEASE, RUN or HOLD:
  - Next edge: dom_rst all ones, all_released 0, state → WAIT_LOCK.
  - lock_loss_cnt increments, saturating at 255.
  - In HOLD, no ack is issued.
- Simultaneous lock loss and soft_rst_req in RUN: lock loss wins; the request stays pending as a level.
- soft_rst_req is level-sensitive. If the requester still holds it when RUN is re-entered, a new HOLD starts; requesters must drop req on ack.
- state_o encodings: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3, HOLD=4. Values 5–7 are illegal and recover to WAIT_LOCK with all resets asserted.
- Pin-to-dom_rst assertion latency on lock loss in RUN is 3 cycles: 2 synchroniser + 1 register.

Decomposition:
- Shared header rst_seq_defs.vh: state encodings and the lock_loss_cnt saturation value.
- One sub-module, sync_2ff (1-bit two-flop synchroniser with synchronous active-high clear), instantiated for pll_locked.

Test Plan (all with defaults, N_DOM=4):
1. rst released, pll_locked held 1 → STABLE for 256 cycles, then dom_rst steps F→E→C→8→0 at 16/32/48/64 cycles after RELEASE entry; all_released=1 on the same edge as dom_rst=0; lock_loss_cnt=0.
2. pll_locked drops for 3 cycles at STABLE count 100, then returns → back to WAIT_LOCK, lock_loss_cnt stays 0; dom_rst[0] falls no earlier than 256+16 cycles after locked_s returns.
3. In RUN, pll_locked drops → dom_rst=F exactly 3 cycles after the pin edge; all_released=0; lock_loss_cnt=1; full resequence when lock returns.
4. In RUN, 1-cycle soft_rst_req → dom_rst=F next edge; soft_rst_ack pulse 64 cycles later; rerelease at +16/32/48/64; lock_loss_cnt unchanged.
5. soft_rst_req and lock drop reach the FSM in the same cycle → WAIT_LOCK, no ack, lock_loss_cnt+1; with req held, HOLD is entered after relock and full release.
6. rst asserted mid-RELEASE (dom_rst=C) → all reset values after one edge; 300 lock-loss cycles afterwards → lock_loss_cnt saturates at 255.

Source files
------------

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: state encodings and the
// lock-loss counter saturation helper.
package rst_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam logic [7:0] LOSS_SAT = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == LOSS_SAT) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a
// synchronous active-high clear.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture the async level, then re-time it once more before use.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a stable PLL lock, releases domain resets in
// order with fixed gaps, and reasserts them on lock loss or soft reset.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int N_DOM           = 4,
    parameter int LOCK_STABLE_CYC = 256,
    parameter int STEP_GAP_CYC    = 16,
    parameter int SRST_HOLD_CYC   = 64,
    parameter int CNT_W           = 16
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    output logic [N_DOM-1:0] dom_rst,
    output logic             all_released,
    output logic [2:0]       state_o,
    output logic [7:0]       lock_loss_cnt
);

    localparam int               IDX_W       = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_DOM - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STEP_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SRST_HOLD_CYC - 1);
    localparam logic [N_DOM-1:0] ALL_ON      = {N_DOM{1'b1}};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk (clk_100m),
        .clr (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign state_o = state_r;

    // Sequencer FSM; one counter serves the stable, gap and hold phases.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_r       <= ST_WAIT_LOCK;
            cnt_r         <= '0;
            idx_r         <= '0;
            dom_rst       <= ALL_ON;
            all_released  <= 1'b0;
            soft_rst_ack  <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            soft_rst_ack <= 1'b0;
            case (state_r)
                ST_WAIT_LOCK: begin
                    dom_rst      <= ALL_ON;
                    all_released <= 1'b0;
                    cnt_r        <= '0;
                    if (locked_s) begin
                        state_r <= ST_STABLE;
                    end else begin
                        state_r <= ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= ST_RELEASE;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_r       <= ST_WAIT_LOCK;
                        dom_rst       <= ALL_ON;
                        all_released  <= 1'b0;
                        cnt_r         <= '0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (cnt_r == GAP_LAST) begin
                        cnt_r          <= '0;
                        dom_rst[idx_r] <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            idx_r        <= '0;
                            state_r      <= ST_RUN;
                            all_released <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Lock loss takes priority; a held request is seen again later.
                    if (!locked_s) begin
                        state_r       <= ST_WAIT_LOCK;
                        dom_rst       <= ALL_ON;
                        all_released  <= 1'b0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (soft_rst_req) begin
                        state_r      <= ST_HOLD;
                        dom_rst      <= ALL_ON;
                        all_released <= 1'b0;
                        cnt_r        <= '0;
                    end else begin
                        dom_rst <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!locked_s) begin
                        state_r       <= ST_WAIT_LOCK;
                        cnt_r         <= '0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (cnt_r == HOLD_LAST) begin
                        state_r      <= ST_RELEASE;
                        soft_rst_ack <= 1'b1;
                        cnt_r        <= '0;
                        idx_r        <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                    dom_rst      <= ALL_ON;
                    all_released <= 1'b0;
                end
                default: begin
                    state_r      <= ST_WAIT_LOCK;
                    cnt_r        <= '0;
                    idx_r        <= '0;
                    dom_rst      <= ALL_ON;
                    all_released <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: table-driven power-up sequence, directed corner
// sequences, randomized run against a reference model, and saturation.
module tb_rst_seq_ctrl;

    localparam int N    = 4;
    localparam int LOCK = 256;
    localparam int GAP  = 16;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       rst, pin, req;
    logic       ack, all_rel;
    logic [3:0] dom;
    logic [2:0] st;
    logic [7:0] loss;

    logic       rst2, pin2, req2;
    logic       ack2, all_rel2;
    logic [3:0] dom2;
    logic [2:0] st2;
    logic [7:0] loss2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl dut (
        .clk_100m(clk), .rst(rst), .pll_locked(pin), .soft_rst_req(req),
        .soft_rst_ack(ack), .dom_rst(dom), .all_released(all_rel),
        .state_o(st), .lock_loss_cnt(loss)
    );

    rst_seq_ctrl #(.N_DOM(4), .LOCK_STABLE_CYC(2), .STEP_GAP_CYC(1),
                   .SRST_HOLD_CYC(1), .CNT_W(16)) dut_small (
        .clk_100m(clk), .rst(rst2), .pll_locked(pin2), .soft_rst_req(req2),
        .soft_rst_ack(ack2), .dom_rst(dom2), .all_released(all_rel2),
        .state_o(st2), .lock_loss_cnt(loss2)
    );

    typedef struct {
        int         cyc;
        logic       rst;
        logic       pin;
        logic       req;
        logic [3:0] dom;
        logic [2:0] st;
        logic       all;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[11];

    // Reference model: phase number, cycles elapsed in phase, lock delay line.
    int   m_phase, m_e, m_loss;
    logic m_s1, m_s2, m_ack;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic cond(input int sel, input logic [3:0] tgt);
        case (sel)
            0: return all_rel;
            1: return st == tgt[2:0];
            2: return dom == tgt;
            3: return ack;
            4: return st2 == tgt[2:0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input logic [3:0] tgt, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (cond(sel, tgt)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic model_step(input logic p, input logic q, input logic r);
        logic lk;
        if (r) begin
            m_phase = 0; m_e = 0; m_loss = 0; m_ack = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            lk    = m_s2;
            m_ack = 1'b0;
            if (!lk && m_phase >= 2) begin
                m_phase = 0;
                m_e     = 0;
                if (m_loss < 255) m_loss++;
            end else begin
                case (m_phase)
                    0: if (lk) begin m_phase = 1; m_e = 0; end
                    1: if (!lk) m_phase = 0;
                       else if (m_e == LOCK - 1) begin m_phase = 2; m_e = 0; end
                       else m_e++;
                    2: begin
                        m_e++;
                        if (m_e == N * GAP) m_phase = 3;
                    end
                    3: if (q) begin m_phase = 4; m_e = 0; end
                    4: if (m_e == HOLD - 1) begin m_phase = 2; m_e = 0; m_ack = 1'b1; end
                       else m_e++;
                    default: m_phase = 0;
                endcase
            end
            m_s2 = m_s1;
            m_s1 = p;
        end
    endtask

    function automatic logic [3:0] model_dom();
        logic [3:0] full;
        full = 4'hF;
        if (m_phase == 2) return full << (m_e / GAP);
        if (m_phase == 3) return 4'h0;
        return full;
    endfunction

    initial begin
        int n;
        int low_left;
        logic [3:0] steps[4];
        logic [7:0] loss_before;
        steps = '{4'hE, 4'hC, 4'h8, 4'h0};

        rst = 1'b1; pin = 1'b1; req = 1'b0;
        rst2 = 1'b1; pin2 = 1'b0; req2 = 1'b0;

        // Power-up: reset, lock held, stable window, stepped release.
        tbl[0]  = '{2,   1'b1, 1'b1, 1'b0, 4'hF, 3'd0, 1'b0, 8'd0};
        tbl[1]  = '{2,   1'b0, 1'b1, 1'b0, 4'hF, 3'd0, 1'b0, 8'd0};
        tbl[2]  = '{1,   1'b0, 1'b1, 1'b0, 4'hF, 3'd1, 1'b0, 8'd0};
        tbl[3]  = '{255, 1'b0, 1'b1, 1'b0, 4'hF, 3'd1, 1'b0, 8'd0};
        tbl[4]  = '{1,   1'b0, 1'b1, 1'b0, 4'hF, 3'd2, 1'b0, 8'd0};
        tbl[5]  = '{15,  1'b0, 1'b1, 1'b0, 4'hF, 3'd2, 1'b0, 8'd0};
        tbl[6]  = '{1,   1'b0, 1'b1, 1'b0, 4'hE, 3'd2, 1'b0, 8'd0};
        tbl[7]  = '{16,  1'b0, 1'b1, 1'b0, 4'hC, 3'd2, 1'b0, 8'd0};
        tbl[8]  = '{16,  1'b0, 1'b1, 1'b0, 4'h8, 3'd2, 1'b0, 8'd0};
        tbl[9]  = '{15,  1'b0, 1'b1, 1'b0, 4'h8, 3'd2, 1'b0, 8'd0};
        tbl[10] = '{1,   1'b0, 1'b1, 1'b0, 4'h0, 3'd3, 1'b1, 8'd0};

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; pin = tbl[i].pin; req = tbl[i].req;
            repeat (tbl[i].cyc) tick();
            chk($sformatf("t1_dom[%0d]", i),  int'(dom),     int'(tbl[i].dom));
            chk($sformatf("t1_st[%0d]", i),   int'(st),      int'(tbl[i].st));
            chk($sformatf("t1_all[%0d]", i),  int'(all_rel), int'(tbl[i].all));
            chk($sformatf("t1_loss[%0d]", i), int'(loss),    int'(tbl[i].loss));
        end

        // Lock loss in RUN: 3-cycle pin-to-reset latency, then full resequence.
        pin = 1'b0;
        tick(); tick();
        chk("t3_dom_pre", int'(dom), 0);
        tick();
        chk("t3_dom", int'(dom), 15);
        chk("t3_st", int'(st), 0);
        chk("t3_all", int'(all_rel), 0);
        chk("t3_loss", int'(loss), 1);
        pin = 1'b1;
        wait_cond(0, 4'h0, 400, n);
        chk("t3_reseq_cycles", n, 323);

        // Short soft-reset request in RUN.
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("t4_dom", int'(dom), 15);
        chk("t4_st", int'(st), 4);
        chk("t4_all", int'(all_rel), 0);
        wait_cond(3, 4'h0, 100, n);
        chk("t4_ack_cycles", n, HOLD);
        chk("t4_st_after_ack", int'(st), 2);
        tick();
        chk("t4_ack_pulse_len", int'(ack), 0);
        for (int k = 0; k < 4; k++) begin
            wait_cond(2, steps[k], 40, n);
            chk($sformatf("t4_step[%0d]", k), n, (k == 0) ? GAP - 1 : GAP);
        end
        chk("t4_all_end", int'(all_rel), 1);
        chk("t4_loss", int'(loss), 1);

        // Lock loss and request reach the FSM together; request kept as level.
        pin = 1'b0;
        tick(); tick();
        req = 1'b1;
        tick();
        chk("t5_st", int'(st), 0);
        chk("t5_ack", int'(ack), 0);
        chk("t5_loss", int'(loss), 2);
        pin = 1'b1;
        wait_cond(1, 4'h4, 400, n);
        chk("t5_hold_cycles", n, 324);
        req = 1'b0;
        wait_cond(3, 4'h0, 100, n);
        chk("t5_ack_cycles", n, HOLD);
        wait_cond(2, 4'hC, 60, n);
        chk("t5_dom_c_cycles", n, 2 * GAP);

        // Synchronous reset mid-release.
        rst = 1'b1;
        tick();
        chk("t6_dom", int'(dom), 15);
        chk("t6_st", int'(st), 0);
        chk("t6_all", int'(all_rel), 0);
        chk("t6_ack", int'(ack), 0);
        chk("t6_loss", int'(loss), 0);

        // Glitch during STABLE restarts the lock window without counting a loss.
        rst = 1'b0;
        wait_cond(1, 4'h1, 10, n);
        chk("t2_stable_entry", n, 3);
        repeat (100) tick();
        pin = 1'b0;
        repeat (3) tick();
        chk("t2_st_wait", int'(st), 0);
        pin = 1'b1;
        wait_cond(2, 4'hE, 400, n);
        chk("t2_dom0_cycles", n, LOCK + GAP + 3);
        chk("t2_loss", int'(loss), 0);

        // Randomized run against the reference model.
        rst = 1'b1;
        model_step(pin, req, rst);
        tick();
        low_left = 0;
        for (int c = 0; c < 8000; c++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if (low_left > 0) begin
                pin = 1'b0;
                low_left--;
            end else begin
                pin = 1'b1;
                if ($urandom_range(0, 899) == 0) low_left = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 39) == 0) req = ~req;
            model_step(pin, req, rst);
            tick();
            chk("rnd_dom", int'(dom), int'(model_dom()));
            chk("rnd_st", int'(st), m_phase);
            chk("rnd_all", int'(all_rel), int'(m_phase == 3));
            chk("rnd_ack", int'(ack), int'(m_ack));
            chk("rnd_loss", int'(loss), m_loss);
        end

        // Lock-loss counter saturation on a fast-parameter instance.
        rst2 = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            loss_before = loss2;
            pin2 = 1'b1;
            wait_cond(4, 4'h2, 20, n);
            chk("sat_release_reached", int'(n > 0), 1);
            pin2 = 1'b0;
            wait_cond(4, 4'h0, 20, n);
            chk("sat_wait_reached", int'(n > 0), 1);
            if (i == 0) chk("sat_first", int'(loss2), int'(loss_before) + 1);
            if (i == 253) chk("sat_254", int'(loss2), 254);
        end
        chk("sat_loss", int'(loss2), 255);
        chk("sat_dom", int'(dom2), 15);
        chk("sat_all", int'(all_rel2), 0);
        chk("sat_ack", int'(ack2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
